// File: rtl/alu_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// alu_sweep_ctrl
//
// Purpose:
//   Steps the select lines of ALU_module through every combination of
//   operation, operand pair and result view. Each setting is held for DWELL
//   clock cycles, so a person watching the board has time to read it. A sweep
//   can be paused, single-stepped while paused, restarted at any time, and it
//   stops on the last combination.
//
//   The view order is: c_led_sw counts fastest (0..LAST_VIEW), then ab_sw
//   (0..7), then alu_op (0..7). The sweep finishes on 7/7/LAST_VIEW and does
//   not wrap back to 0.
//
// Parameters:
//   DWELL      clock cycles each setting is held (2 .. 2^26-1)
//   LAST_VIEW  highest c_led_sw value stepped through
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle pulse, begins or restarts a sweep
//   pause     in   level, freezes the sweep while high
//   step      in   one-cycle pulse, advances one view while paused
//   alu_op    out  [2:0] operation select to ALU_module
//   ab_sw     out  [2:0] operand-pair select to ALU_module
//   c_led_sw  out  [2:0] result-view select to ALU_module
//   busy      out  high while sweeping or paused
//   done      out  high once the sweep has finished
//
// All outputs come straight from flip-flops.
// ---------------------------------------------------------------------------
module alu_sweep_ctrl #(
    parameter int DWELL     = 25000000,
    parameter int LAST_VIEW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       step,
    output logic [2:0] alu_op,
    output logic [2:0] ab_sw,
    output logic [2:0] c_led_sw,
    output logic       busy,
    output logic       done
);

    // DWELL is at least 2, so this width is always at least one bit and
    // holds DWELL-1 exactly without overflow.
    localparam int                CNT_W     = $clog2(DWELL);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [2:0]        VIEW_LAST = 3'(LAST_VIEW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] dwell_nxt;
    logic [2:0]       alu_nxt;
    logic [2:0]       ab_nxt;
    logic [2:0]       c_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [2:0]       adv_alu;
    logic [2:0]       adv_ab;
    logic [2:0]       adv_c;
    logic             adv_final;
    logic             dwell_end;

    // Works out what the selects would become if the sweep moved on by one
    // view right now. adv_final flags the last combination: moving on from
    // there ends the sweep instead of wrapping.
    always_comb begin
        adv_final = (alu_op == 3'd7) && (ab_sw == 3'd7) && (c_led_sw == VIEW_LAST);
        adv_alu   = alu_op;
        adv_ab    = ab_sw;
        adv_c     = c_led_sw + 3'd1;
        if (c_led_sw == VIEW_LAST) begin
            adv_c  = 3'd0;
            adv_ab = ab_sw + 3'd1;
            if (ab_sw == 3'd7) begin
                adv_alu = alu_op + 3'd1;
            end
        end
    end

    // Next-state and next-output logic. Everything holds its value unless
    // something below changes it. start overrides all other inputs in every
    // state. In RUN with pause high, the dwell counter stops. If that cycle
    // is also the last dwell cycle, the view still advances on the same edge
    // before the sweep drops into HOLD. Leaving HOLD keeps the frozen count,
    // so the dwell that was interrupted continues where it stopped. A step in
    // HOLD starts a fresh dwell for the new view.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        alu_nxt   = alu_op;
        ab_nxt    = ab_sw;
        c_nxt     = c_led_sw;
        dwell_end = (dwell_cnt == CNT_LAST);

        if (start) begin
            state_nxt = RUN;
            dwell_nxt = '0;
            alu_nxt   = 3'd0;
            ab_nxt    = 3'd0;
            c_nxt     = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (dwell_end) begin
                        dwell_nxt = '0;
                        if (adv_final) begin
                            state_nxt = DONE;
                        end else begin
                            alu_nxt = adv_alu;
                            ab_nxt  = adv_ab;
                            c_nxt   = adv_c;
                        end
                    end else if (!pause) begin
                        dwell_nxt = dwell_cnt + 1'b1;
                    end
                    if (pause && !(dwell_end && adv_final)) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end else if (step) begin
                        dwell_nxt = '0;
                        if (adv_final) begin
                            state_nxt = DONE;
                        end else begin
                            alu_nxt = adv_alu;
                            ab_nxt  = adv_ab;
                            c_nxt   = adv_c;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        busy_nxt = (state_nxt == RUN) || (state_nxt == HOLD);
        done_nxt = (state_nxt == DONE);
    end

    // State, counter and output registers. busy and done are registered from
    // the next state, so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            alu_op    <= 3'd0;
            ab_sw     <= 3'd0;
            c_led_sw  <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            alu_op    <= alu_nxt;
            ab_sw     <= ab_nxt;
            c_led_sw  <= c_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_sweep_ctrl
//
// Exercises alu_sweep_ctrl with DWELL=4 and LAST_VIEW=4.
//
// The reference model treats the sweep as one linear view index, 0..319.
// The selects are derived from that index by division and modulo, and the
// model follows the controller's rules for each cycle. Every driven cycle
// pushes its expected outputs onto a queue. A separate monitor pops one
// entry after each clock edge and compares it with the DUT. Directed
// checkpoints compare against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_alu_sweep_ctrl;

    localparam int DWELL      = 4;
    localparam int LAST_VIEW  = 4;
    localparam int VIEWS      = LAST_VIEW + 1;
    localparam int LAST_INDEX = 8 * 8 * VIEWS - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       step;
    logic [2:0] alu_op;
    logic [2:0] ab_sw;
    logic [2:0] c_led_sw;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [2:0] alu;
        logic [2:0] ab;
        logic [2:0] c;
        logic       busy;
        logic       done;
    } sample_t;

    typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;

    sample_t exp_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;

    mode_t   m_mode  = M_IDLE;
    int      m_view  = 0;
    int      m_cnt   = 0;

    alu_sweep_ctrl #(
        .DWELL    (DWELL),
        .LAST_VIEW(LAST_VIEW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .pause   (pause),
        .step    (step),
        .alu_op  (alu_op),
        .ab_sw   (ab_sw),
        .c_led_sw(c_led_sw),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        forever #5 clk = ~clk;
    end

    // Converts the model's linear view index and mode into the expected
    // outputs.
    function automatic sample_t model_outputs(int view, mode_t mode);
        sample_t s;
        s.alu  = 3'(view / (8 * VIEWS));
        s.ab   = 3'((view / VIEWS) % 8);
        s.c    = 3'(view % VIEWS);
        s.busy = (mode == M_RUN) || (mode == M_HOLD);
        s.done = (mode == M_DONE);
        return s;
    endfunction

    // Applies one clock edge of the controller's rules to the model.
    task automatic model_step(input logic s, input logic p, input logic st, input logic r);
        if (!r) begin
            m_mode = M_IDLE;
            m_view = 0;
            m_cnt  = 0;
        end else if (s) begin
            m_mode = M_RUN;
            m_view = 0;
            m_cnt  = 0;
        end else if (m_mode == M_RUN) begin
            if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                if (m_view == LAST_INDEX) m_mode = M_DONE;
                else m_view++;
            end else if (!p) begin
                m_cnt++;
            end
            if (p && m_mode == M_RUN) m_mode = M_HOLD;
        end else if (m_mode == M_HOLD) begin
            if (!p) begin
                m_mode = M_RUN;
            end else if (st) begin
                m_cnt = 0;
                if (m_view == LAST_INDEX) m_mode = M_DONE;
                else m_view++;
            end
        end
    endtask

    // Drives one cycle of inputs at the falling edge. Also records the
    // outputs the model expects after the next rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic st, input logic r);
        @(negedge clk);
        start = s;
        pause = p;
        step  = st;
        rst_n = r;
        model_step(s, p, st, r);
        exp_q.push_back(model_outputs(m_view, m_mode));
    endtask

    // Directed checkpoint. Waits for the edge that applies the last stimulus,
    // then compares the DUT with hand-derived constants.
    task automatic checkOutput(input string name, input int e_alu, input int e_ab,
                               input int e_c, input logic e_busy, input logic e_done);
        @(posedge clk);
        #2;
        tests_run++;
        if (alu_op !== 3'(e_alu) || ab_sw !== 3'(e_ab) || c_led_sw !== 3'(e_c) ||
            busy !== e_busy || done !== e_done) begin
            tests_failed++;
            $display("[TB] FAIL %s: got op/ab/c/busy/done=%0d/%0d/%0d/%b/%b required %0d/%0d/%0d/%b/%b",
                     name, alu_op, ab_sw, c_led_sw, busy, done, e_alu, e_ab, e_c, e_busy, e_done);
        end
    endtask

    // Scoreboard monitor. After every rising edge, pops the expected sample
    // for that edge, if one is queued, and compares it with the DUT.
    initial begin
        sample_t e;
        sample_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{alu_op, ab_sw, c_led_sw, busy, done};
                tests_run++;
                if (got !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard @%0t: got op/ab/c/busy/done=%0d/%0d/%0d/%b/%b required %0d/%0d/%0d/%b/%b",
                             $time, got.alu, got.ab, got.c, got.busy, got.done,
                             e.alu, e.ab, e.c, e.busy, e.done);
                end
            end
        end
    end

    // Directed scenarios first, then a randomized soak. Finally, the bench
    // drains the scoreboard and prints the summary.
    initial begin
        logic r_rst;
        logic r_start;
        logic r_pause;
        logic r_step;

        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        step  = 1'b0;

        // Reset, and a stray step in IDLE.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("step_in_idle", 0, 0, 0, 1'b0, 1'b0);

        // Uninterrupted sweep with timing checkpoints.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("start_entry", 0, 0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 1330; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 3)    checkOutput("dwell_hold",  0, 0, 0, 1'b1, 1'b0);
            if (i == 4)    checkOutput("first_view",  0, 0, 1, 1'b1, 1'b0);
            if (i == 20)   checkOutput("first_pair",  0, 1, 0, 1'b1, 1'b0);
            if (i == 160)  checkOutput("first_op",    1, 0, 0, 1'b1, 1'b0);
            if (i == 1279) checkOutput("last_view",   7, 7, 4, 1'b1, 1'b0);
            if (i == 1280) checkOutput("sweep_done",  7, 7, 4, 1'b0, 1'b1);
            if (i == 1330) checkOutput("done_held",   7, 7, 4, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("step_in_done", 7, 7, 4, 1'b0, 1'b1);

        // Pause at dwell count 2, single-step three views, then resume.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("pause_frozen", 0, 0, 0, 1'b1, 1'b0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("three_steps", 0, 0, 3, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_wait", 0, 0, 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_adv", 0, 0, 4, 1'b1, 1'b0);

        // Reach 3/5/2 (view 147), run briefly, then restart mid-sweep.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (147) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_sweep", 3, 5, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("restart_mid", 0, 0, 0, 1'b1, 1'b0);

        // Step all the way to the last view in HOLD, then step into DONE.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (LAST_INDEX) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("hold_last", 7, 7, 4, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("step_to_done", 7, 7, 4, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_done", 0, 0, 0, 1'b1, 1'b0);

        // Reset during RUN with start and step both high, then start
        // immediately after reset is released.
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("reset_in_run", 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("start_after_rst", 0, 0, 0, 1'b1, 1'b0);

        // Randomized soak, checked by the scoreboard alone.
        r_pause = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_rst   = ($urandom_range(0, 499) != 0);
            r_start = ($urandom_range(0, 149) == 0);
            r_step  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) r_pause = ~r_pause;
            applyStimulus(r_start, r_pause, r_step, r_rst);
        end

        // Let the monitor consume what is still queued, within a bound.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d samples left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
